bcd_counter_ndigit: RTL and testbench

Parametrised N-digit BCD up/down counter with a programmable terminal value, synchronous clear and load, and a wrap or saturate mode. It is the general form of the team's two-digit decimal counter. It feeds seven-segment display drivers and timers with packed BCD digits directly, so no divide or modulo stage is needed downstream. Arithmetic is done digit-wise in BCD, with a decimal carry or borrow rippling through all digits in a single cycle.

---
 rtl/bcd_counter_ndigit_if.sv | 29 ++
 rtl/bcd_counter_ndigit.sv | 133 +++++++++++++
 tb/tb_bcd_counter_ndigit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_ndigit_if.sv
// Control and status bundle for the N-digit BCD counter.
// The master side drives controls and the terminal value; the slave side returns the count and flags.
interface bcd_counter_ndigit_if #(
   parameter int unsigned DIGITS = 2
);
   localparam int unsigned W = 4 * DIGITS;

   logic         clear;
   logic         load;
   logic [W-1:0] load_val;
   logic         en;
   logic         up;
   logic [W-1:0] top;
   logic [W-1:0] count;
   logic         rollover;
   logic         at_top;
   logic         at_zero;
   logic         load_err;

   modport master (
      output clear, load, load_val, en, up, top,
      input  count, rollover, at_top, at_zero, load_err
   );

   modport slave (
      input  clear, load, load_val, en, up, top,
      output count, rollover, at_top, at_zero, load_err
   );
endinterface

// File: rtl/bcd_counter_ndigit.sv
// Parametrised N-digit packed-BCD up/down counter with a programmable terminal value.
// Supports wrap or saturate at the limits; the carry and borrow ripple through every digit in one cycle.
module bcd_counter_ndigit #(
   parameter int unsigned DIGITS   = 2,
   parameter bit          SATURATE = 1'b0
) (
   input logic                clk,
   input logic                reset,
   bcd_counter_ndigit_if.slave bus
);
   localparam int unsigned W = 4 * DIGITS;

   logic [W-1:0] count_q, count_nxt;
   logic         roll_q, roll_nxt;
   logic         lerr_q, lerr_nxt;
   logic [W-1:0] top_clamped;
   logic [W-1:0] load_clamped;
   logic         load_bad;
   logic [W-1:0] count_inc;
   logic [W-1:0] count_dec;

   // Force every digit into 0..9 so that the comparisons and the wrap targets remain valid BCD.
   function automatic logic [W-1:0] clamp_digits(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < DIGITS; i++)
         r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
      return r;
   endfunction

   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = 4'(v[4*i +: 4] + 4'd1);
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
      logic [W-1:0] r;
      logic         borrow;
      r      = v;
      borrow = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = 4'(v[4*i +: 4] - 4'd1);
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign top_clamped  = clamp_digits(bus.top);
   assign load_clamped = clamp_digits(bus.load_val);
   assign load_bad     = has_bad_digit(bus.load_val);
   assign count_inc    = bcd_inc(count_q);
   assign count_dec    = bcd_dec(count_q);

   // Valid BCD words order the same way as their binary encodings, so plain compares are enough.
   always_comb begin
      count_nxt = count_q;
      roll_nxt  = 1'b0;
      lerr_nxt  = 1'b0;
      if (bus.clear) begin
         count_nxt = '0;
      end else if (bus.load) begin
         count_nxt = load_clamped;
         lerr_nxt  = load_bad;
      end else if (bus.en) begin
         if (bus.up) begin
            if (count_q < top_clamped) begin
               count_nxt = count_inc;
            end else if (SATURATE) begin
               count_nxt = top_clamped;
            end else begin
               count_nxt = '0;
               roll_nxt  = 1'b1;
            end
         end else begin
            if (count_q == '0) begin
               if (!SATURATE) begin
                  count_nxt = top_clamped;
                  roll_nxt  = 1'b1;
               end
            end else if (count_q > top_clamped) begin
               count_nxt = top_clamped;
            end else begin
               count_nxt = count_dec;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         roll_q  <= 1'b0;
         lerr_q  <= 1'b0;
      end else begin
         count_q <= count_nxt;
         roll_q  <= roll_nxt;
         lerr_q  <= lerr_nxt;
      end
   end

   assign bus.count    = count_q;
   assign bus.rollover = roll_q;
   assign bus.load_err = lerr_q;
   assign bus.at_top   = (count_q == top_clamped);
   assign bus.at_zero  = (count_q == '0);
endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Scoreboard bench for bcd_counter_ndigit: a wrapping and a saturating two-digit instance.
// Directed steps push their expected results into a queue, and per-instance monitors pop and compare them.
module tb_bcd_counter_ndigit;
   typedef struct {
      logic [7:0] cnt;
      logic       roll;
      logic       lerr;
      logic [7:0] tp;
      string      nm;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   bcd_counter_ndigit_if #(.DIGITS(2)) bus0 ();
   bcd_counter_ndigit_if #(.DIGITS(2)) bus1 ();

   bcd_counter_ndigit #(.DIGITS(2), .SATURATE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   bcd_counter_ndigit #(.DIGITS(2), .SATURATE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] clamp8(input logic [7:0] v);
      logic [3:0] hi, lo;
      hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
      lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
      return {hi, lo};
   endfunction

   function automatic logic [7:0] bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   task automatic push(input int d, input logic [7:0] c, input logic r, input logic l,
                       input logic [7:0] tp, input string nm);
      exp_t e;
      e.cnt = c; e.roll = r; e.lerr = l; e.tp = tp; e.nm = nm;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic step(input int d, input logic clr, input logic ld, input logic [7:0] lv,
                       input logic e, input logic u, input logic [7:0] tp,
                       input logic [7:0] c, input logic r, input logic l, input string nm);
      @(negedge clk);
      if (d == 0) begin
         bus0.clear = clr; bus0.load = ld; bus0.load_val = lv; bus0.en = e; bus0.up = u; bus0.top = tp;
      end else begin
         bus1.clear = clr; bus1.load = ld; bus1.load_val = lv; bus1.en = e; bus1.up = u; bus1.top = tp;
      end
      push(d, c, r, l, tp, nm);
   endtask

   task automatic compare(input exp_t e, input logic [7:0] c, input logic r, input logic l,
                          input logic at, input logic az);
      chk({e.nm, "_count"},    c,      e.cnt);
      chk({e.nm, "_rollover"}, 8'(r),  8'(e.roll));
      chk({e.nm, "_load_err"}, 8'(l),  8'(e.lerr));
      chk({e.nm, "_at_top"},   8'(at), 8'(clamp8(e.tp) == e.cnt));
      chk({e.nm, "_at_zero"},  8'(az), 8'(e.cnt == 8'h00));
   endtask

   // Monitors: after each active edge, pop one expected entry per instance when one is pending.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q0.size() != 0) begin
            e = q0.pop_front();
            compare(e, bus0.count, bus0.rollover, bus0.load_err, bus0.at_top, bus0.at_zero);
         end
         if (q1.size() != 0) begin
            e = q1.pop_front();
            compare(e, bus1.count, bus1.rollover, bus1.load_err, bus1.at_top, bus1.at_zero);
         end
      end
   end

   initial begin
      reset = 1'b1;
      bus0.clear = 0; bus0.load = 0; bus0.load_val = 0; bus0.en = 0; bus0.up = 0; bus0.top = 8'h99;
      bus1.clear = 0; bus1.load = 0; bus1.load_val = 0; bus1.en = 0; bus1.up = 0; bus1.top = 8'h25;
      #12;
      chk("reset_count",    bus0.count, 8'h00);
      chk("reset_rollover", 8'(bus0.rollover), 8'h0);
      chk("reset_load_err", 8'(bus0.load_err), 8'h0);
      chk("reset_at_zero",  8'(bus0.at_zero),  8'h1);
      chk("reset_at_top",   8'(bus0.at_top),   8'h0);
      chk("reset_count_sat", bus1.count, 8'h00);
      reset = 1'b0;

      // Wrapping count-up over a full range: digit carries and a single wrap pulse.
      for (int k = 1; k <= 100; k++)
         step(0, 0, 0, 8'h00, 1, 1, 8'h99, bcd(k % 100), (k % 100) == 0, 0, "t1_up");
      step(0, 0, 0, 8'h00, 0, 1, 8'h99, 8'h00, 0, 0, "t1_hold");

      // Down from zero wraps to top; digit borrow after a load.
      step(0, 0, 0, 8'h00, 1, 0, 8'h59, 8'h59, 1, 0, "t2_wrap_dn");
      step(0, 0, 0, 8'h00, 1, 0, 8'h59, 8'h58, 0, 0, "t2_dn");
      step(0, 0, 1, 8'h10, 0, 0, 8'h59, 8'h10, 0, 0, "t2_load");
      step(0, 0, 0, 8'h00, 1, 0, 8'h59, 8'h09, 0, 0, "t2_borrow");
      step(0, 0, 0, 8'h00, 1, 0, 8'h59, 8'h08, 0, 0, "t2_dn2");

      // Load clamping, load_err pulse, above-top recovery.
      step(0, 0, 1, 8'h3C, 0, 0, 8'h59, 8'h39, 0, 1, "t4_clamp");
      step(0, 0, 0, 8'h00, 0, 0, 8'h59, 8'h39, 0, 0, "t4_lerr_drop");
      step(0, 0, 1, 8'h80, 0, 0, 8'h59, 8'h80, 0, 0, "t4_load_above");
      step(0, 0, 0, 8'h00, 1, 0, 8'h59, 8'h59, 0, 0, "t4_dn_to_top");
      step(0, 0, 0, 8'h00, 1, 1, 8'h59, 8'h00, 1, 0, "t4_up_wrap");
      step(0, 0, 1, 8'hA5, 0, 0, 8'h59, 8'h95, 0, 1, "t4_clamp_hi");

      // Priority: clear over load over en.
      step(0, 1, 1, 8'h42, 1, 1, 8'h59, 8'h00, 0, 0, "t5_clear_wins");
      step(0, 0, 1, 8'h42, 1, 1, 8'h59, 8'h42, 0, 0, "t5_load_wins");

      // top==0 pulses every enabled cycle; invalid top digits are clamped.
      step(0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1, 0, "t7_top0_up");
      step(0, 0, 0, 8'h00, 1, 1, 8'h00, 8'h00, 1, 0, "t7_top0_up2");
      step(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, "t7_top0_dn");
      step(0, 0, 0, 8'h00, 1, 0, 8'h5F, 8'h59, 1, 0, "t7_badtop_dn");
      step(0, 0, 0, 8'h00, 1, 1, 8'h5F, 8'h00, 1, 0, "t7_badtop_up");

      // Asynchronous reset mid-cycle with load and en active.
      step(0, 0, 1, 8'h47, 1, 1, 8'h99, 8'h47, 0, 0, "t6_load");
      @(posedge clk);
      #3;
      reset = 1'b1;
      bus0.load = 1'b0;
      #1;
      chk("t6_async_count",    bus0.count, 8'h00);
      chk("t6_async_rollover", 8'(bus0.rollover), 8'h0);
      push(0, 8'h00, 0, 0, 8'h99, "t6_in_reset");
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      push(0, 8'h01, 0, 0, 8'h99, "t6_release");
      step(0, 0, 0, 8'h00, 0, 1, 8'h99, 8'h01, 0, 0, "t6_hold");

      // Saturating instance: hold at top going up, hold at zero going down.
      step(1, 0, 1, 8'h24, 0, 1, 8'h25, 8'h24, 0, 0, "t3_load");
      step(1, 0, 0, 8'h00, 1, 1, 8'h25, 8'h25, 0, 0, "t3_up_top");
      for (int k = 0; k < 3; k++)
         step(1, 0, 0, 8'h00, 1, 1, 8'h25, 8'h25, 0, 0, "t3_sat_hold");
      step(1, 0, 1, 8'h30, 0, 1, 8'h25, 8'h30, 0, 0, "t3_load_above");
      step(1, 0, 0, 8'h00, 1, 1, 8'h25, 8'h25, 0, 0, "t3_up_above");
      step(1, 1, 0, 8'h00, 0, 0, 8'h25, 8'h00, 0, 0, "t3_clear");
      step(1, 0, 0, 8'h00, 1, 0, 8'h25, 8'h00, 0, 0, "t3_dn_zero");
      step(1, 0, 0, 8'h00, 1, 0, 8'h25, 8'h00, 0, 0, "t3_dn_zero2");
      step(1, 0, 0, 8'h00, 0, 0, 8'h25, 8'h00, 0, 0, "t3_idle");

      for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++)
         @(posedge clk);
      #2;
      chk("drain_pending", 8'(q0.size() + q1.size()), 8'h00);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
